// File: rtl/keypad_pkg.sv
// keypad_pkg
//   Shared definitions for the 4x4 keypad scanner.
//   - state_t     : key debounce FSM states (IDLE / DEBOUNCE / PRESSED)
//   - frame_res_t : result of one full four-row scan frame (NONE / ONE / MULTI)
//   - ROWS, COLS  : matrix geometry
//   - ROW_IDLE    : row-drive pattern after reset (row 0 driven low)
//   - row_drive() : active-low one-hot row pattern for a row index
package keypad_pkg;

    localparam int ROWS = 4;
    localparam int COLS = 4;

    localparam logic [ROWS-1:0] ROW_IDLE = 4'b1110;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_PRESSED
    } state_t;

    typedef enum logic [1:0] {
        RES_NONE,
        RES_ONE,
        RES_MULTI
    } frame_res_t;

    function automatic logic [ROWS-1:0] row_drive(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/keypad_if.sv
// keypad_if
//   Groups the keypad matrix lines and the key-event outputs.
//   keypad_col : column sense, active-low, asynchronous (driven by the matrix)
//   keypad_row : row drive, active-low one-hot (driven by the scanner)
//   key_valid  : one-cycle pulse per accepted key event
//   key_code   : row*4+col of the last accepted key
//   key_held   : high while the accepted key remains pressed
//   Modports: master = scanner side, slave = matrix/consumer side.
interface keypad_if;
    logic [3:0] keypad_col;
    logic [3:0] keypad_row;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_held;

    modport master (
        input  keypad_col,
        output keypad_row,
        output key_valid,
        output key_code,
        output key_held
    );

    modport slave (
        output keypad_col,
        input  keypad_row,
        input  key_valid,
        input  key_code,
        input  key_held
    );
endinterface

// File: rtl/keypad_debounce.sv
// keypad_debounce
//   Turns one frame result per scan frame into debounced key events.
//   Ports:
//     clk_10000Hz  : system clock
//     reset        : synchronous, active-high
//     i_frame_end  : strobe, frame result below is valid this cycle
//     i_result     : NONE / ONE / MULTI for the finished frame
//     i_code       : key code when i_result is ONE
//     o_key_valid  : one-cycle event pulse
//     o_key_code   : code of last accepted key
//     o_key_held   : high while in PRESSED
//   Optional feature macro: KEYPAD_REPEAT_EN (auto-repeat while held).
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_DELAY   = 125,
    parameter int REPEAT_RATE    = 25
) (
    input  logic       clk_10000Hz,
    input  logic       reset,
    input  logic       i_frame_end,
    input  frame_res_t i_result,
    input  logic [3:0] i_code,
    output logic       o_key_valid,
    output logic [3:0] o_key_code,
    output logic       o_key_held
);

    if (DEBOUNCE_SCANS < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1 ||
        REPEAT_RATE > REPEAT_DELAY) begin : g_bad_param
        $error("keypad_debounce: invalid debounce/repeat parameters");
    end

    localparam int              CNT_W   = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_TGT = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           r_state, w_state_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx, w_cnt_inc;
    logic [CNT_W-1:0] r_rel_cnt, w_rel_nx, w_rel_inc;
    logic [3:0]       r_cand, w_cand_nx;
    logic             r_key_valid, w_valid_nx;
    logic [3:0]       r_key_code, w_code_nx;

`ifdef KEYPAD_REPEAT_EN
    localparam int              REP_W      = $clog2(REPEAT_DELAY + 1);
    localparam logic [REP_W-1:0] REP_TGT    = REP_W'(REPEAT_DELAY);
    localparam logic [REP_W-1:0] REP_RELOAD = REP_W'(REPEAT_DELAY - REPEAT_RATE);
    logic [REP_W-1:0] r_rep_cnt, w_rep_nx;
`endif

    always_ff @(posedge clk_10000Hz) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_rel_cnt   <= '0;
            r_cand      <= '0;
            r_key_valid <= 1'b0;
            r_key_code  <= '0;
`ifdef KEYPAD_REPEAT_EN
            r_rep_cnt   <= '0;
`endif
        end else begin
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_rel_cnt   <= w_rel_nx;
            r_cand      <= w_cand_nx;
            r_key_valid <= w_valid_nx;
            r_key_code  <= w_code_nx;
`ifdef KEYPAD_REPEAT_EN
            r_rep_cnt   <= w_rep_nx;
`endif
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_rel_nx   = r_rel_cnt;
        w_cand_nx  = r_cand;
        w_valid_nx = 1'b0;
        w_code_nx  = r_key_code;
        // Saturating increments: counters stop at the target, never wrap.
        w_cnt_inc  = (r_cnt == CNT_TGT) ? r_cnt : r_cnt + 1'b1;
        w_rel_inc  = (r_rel_cnt == CNT_TGT) ? r_rel_cnt : r_rel_cnt + 1'b1;
`ifdef KEYPAD_REPEAT_EN
        w_rep_nx   = r_rep_cnt;
`endif

        if (i_frame_end) begin
            case (r_state)
                ST_IDLE: begin
                    if (i_result == RES_ONE) begin
                        w_cand_nx = i_code;
                        w_cnt_nx  = CNT_ONE;
                        if (CNT_ONE == CNT_TGT) begin
                            w_state_nx = ST_PRESSED;
                            w_valid_nx = 1'b1;
                            w_code_nx  = i_code;
                            w_rel_nx   = '0;
                        end else begin
                            w_state_nx = ST_DEBOUNCE;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (i_result == RES_ONE && i_code == r_cand) begin
                        w_cnt_nx = w_cnt_inc;
                        if (w_cnt_inc == CNT_TGT) begin
                            w_state_nx = ST_PRESSED;
                            w_valid_nx = 1'b1;
                            w_code_nx  = r_cand;
                            w_rel_nx   = '0;
                        end
                    end else if (i_result == RES_ONE) begin
                        w_cand_nx = i_code;
                        w_cnt_nx  = CNT_ONE;
                    end else begin
                        w_state_nx = ST_IDLE;
                        w_cnt_nx   = '0;
                    end
                end
                ST_PRESSED: begin
                    // Any key activity (same, other, or several) holds PRESSED;
                    // a new key is only accepted after a full release.
                    if (i_result == RES_NONE) begin
                        if (w_rel_inc == CNT_TGT) begin
                            w_state_nx = ST_IDLE;
                            w_rel_nx   = '0;
                            w_cnt_nx   = '0;
                        end else begin
                            w_rel_nx = w_rel_inc;
                        end
                    end else begin
                        w_rel_nx = '0;
                    end
                end
                default: begin
                    w_state_nx = ST_IDLE;
                    w_cnt_nx   = '0;
                    w_rel_nx   = '0;
                end
            endcase
        end

`ifdef KEYPAD_REPEAT_EN
        // Frames spent in PRESSED; first repeat at REPEAT_DELAY, then the
        // counter reloads so later repeats come every REPEAT_RATE frames.
        if (w_state_nx != ST_PRESSED) begin
            w_rep_nx = '0;
        end else if (i_frame_end && r_state == ST_PRESSED) begin
            if (r_rep_cnt + 1'b1 == REP_TGT) begin
                w_valid_nx = 1'b1;
                w_rep_nx   = REP_RELOAD;
            end else begin
                w_rep_nx = r_rep_cnt + 1'b1;
            end
        end
`endif
    end

    assign o_key_valid = r_key_valid;
    assign o_key_code  = r_key_code;
    assign o_key_held  = (r_state == ST_PRESSED);

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 active-low key matrix one row at a time, synchronises the
//   column lines, classifies each frame and hands the result to
//   keypad_debounce for event generation.
//   Ports:
//     clk_10000Hz : system clock, 10 kHz
//     reset       : synchronous, active-high
//     kp          : keypad_if.master (keypad_col in; keypad_row, key_valid,
//                   key_code, key_held out)
//   Optional feature macro: KEYPAD_REPEAT_EN (auto-repeat, in keypad_debounce).
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 10,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_DELAY   = 125,
    parameter int REPEAT_RATE    = 25
) (
    input  logic     clk_10000Hz,
    input  logic     reset,
    keypad_if.master kp
);

    if (SCAN_DIV < 3) begin : g_bad_div
        $error("keypad_scanner: SCAN_DIV must be >= 3");
    end

    localparam int              DIV_W    = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [3:0]       r_col_s1, r_col_s2;
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_row;
    logic [ROWS-1:0]  r_row_drv;
    logic [1:0]       r_acc_cnt;   // keys seen so far this frame: 0, 1, 2 (= many)
    logic [3:0]       r_acc_code;

    logic [COLS-1:0]  w_hit;
    logic [1:0]       w_row_cnt;
    logic [1:0]       w_col_idx;
    logic [2:0]       w_sum;
    logic             w_sample;
    logic             w_frame_end;
    frame_res_t       w_result;
    logic [3:0]       w_code;
    logic             w_key_valid;
    logic [3:0]       w_key_code;
    logic             w_key_held;

    assign w_sample    = (r_div == DIV_LAST);
    assign w_frame_end = w_sample && (r_row == 2'd3);

    always_comb begin
        w_hit     = ~r_col_s2;
        w_row_cnt = '0;
        w_col_idx = '0;
        // Walk high to low so the lowest pressed column is the one recorded.
        for (int unsigned c = COLS; c > 0; c--) begin
            if (w_hit[2'(c - 1)]) begin
                w_col_idx = 2'(c - 1);
                if (w_row_cnt != 2'd2) begin
                    w_row_cnt = w_row_cnt + 2'd1;
                end
            end
        end
        w_sum    = {1'b0, r_acc_cnt} + {1'b0, w_row_cnt};
        w_result = (w_sum == 3'd0) ? RES_NONE :
                   (w_sum == 3'd1) ? RES_ONE  : RES_MULTI;
        w_code   = (r_acc_cnt != 2'd0) ? r_acc_code : {r_row, w_col_idx};
    end

    always_ff @(posedge clk_10000Hz) begin
        if (reset) begin
            r_col_s1   <= '1;
            r_col_s2   <= '1;
            r_div      <= '0;
            r_row      <= '0;
            r_row_drv  <= ROW_IDLE;
            r_acc_cnt  <= '0;
            r_acc_code <= '0;
        end else begin
            r_col_s1 <= kp.keypad_col;
            r_col_s2 <= r_col_s1;
            if (w_sample) begin
                r_div     <= '0;
                r_row     <= r_row + 2'd1;
                r_row_drv <= row_drive(r_row + 2'd1);
                if (w_frame_end) begin
                    r_acc_cnt  <= '0;
                    r_acc_code <= '0;
                end else begin
                    r_acc_cnt  <= (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
                    r_acc_code <= w_code;
                end
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

    keypad_debounce #(
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_RATE    (REPEAT_RATE)
    ) u_debounce (
        .clk_10000Hz (clk_10000Hz),
        .reset       (reset),
        .i_frame_end (w_frame_end),
        .i_result    (w_result),
        .i_code      (w_code),
        .o_key_valid (w_key_valid),
        .o_key_code  (w_key_code),
        .o_key_held  (w_key_held)
    );

    assign kp.keypad_row = r_row_drv;
    assign kp.key_valid  = w_key_valid;
    assign kp.key_code   = w_key_code;
    assign kp.key_held   = w_key_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
//   Keypad matrix model drives keypad_col from a pressed-key map and the
//   scanned rows. Expected key events are queued when keys are pressed and
//   compared when key_valid pulses.
`timescale 1us/1ns
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] keys;
    int          n_chk = 0;
    int          n_err = 0;
    int          exp_q[$];
    logic        in_bounce = 1'b0;
    int          bounce_hits = 0;

    keypad_if kp ();

    keypad_scanner #(
        .SCAN_DIV       (10),
        .DEBOUNCE_SCANS (4),
        .REPEAT_DELAY   (125),
        .REPEAT_RATE    (25)
    ) dut (
        .clk_10000Hz (clk),
        .reset       (reset),
        .kp          (kp)
    );

    always #50 clk = ~clk;

    // Matrix: a pressed key pulls its column low while its row is driven low.
    always_comb begin
        kp.keypad_col = '1;
        for (int r = 0; r < 4; r++) begin
            if (!kp.keypad_row[r]) begin
                for (int c = 0; c < 4; c++) begin
                    if (keys[r*4 + c]) kp.keypad_col[c] = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Event monitor / scoreboard.
    always @(negedge clk) begin
        if (!reset && kp.key_valid) begin
            if (in_bounce) bounce_hits++;
            if (exp_q.size() == 0) begin
                chk("spurious_valid", {31'd0, kp.key_valid}, 32'd0);
            end else begin
                chk("evt_code", {28'd0, kp.key_code}, exp_q.pop_front());
                chk("evt_held", {31'd0, kp.key_held}, 32'd1);
            end
        end
    end

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_row"},   {28'd0, kp.keypad_row}, 32'hE);
        chk({tag, "_valid"}, {31'd0, kp.key_valid},  32'd0);
        chk({tag, "_code"},  {28'd0, kp.key_code},   32'd0);
        chk({tag, "_held"},  {31'd0, kp.key_held},   32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #6000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b1;
        keys  = '0;
        do_reset("rst0");

        // Key 9 (row 2, col 1) held from reset release: latency and release.
        keys[9] = 1'b1;
        exp_q.push_back(9);
        do_reset("rst_t2");
        n = 0;
        while (n < 400) begin
            @(posedge clk);
            #1;
            n++;
            if (kp.key_valid) break;
        end
        chk("t2_latency", n, 160);
        wait_cyc(2000);
        chk("t2_held", {31'd0, kp.key_held}, 32'd1);
        chk("t2_code", {28'd0, kp.key_code}, 32'd9);
        keys = '0;                       // released at a frame start
        wait_cyc(159);
        chk("t2_held_before_rel", {31'd0, kp.key_held}, 32'd1);
        wait_cyc(1);
        chk("t2_held_after_rel", {31'd0, kp.key_held}, 32'd0);
        chk("t2_missing_evt", exp_q.size(), 0);

        // Reset mid-scan while a key is accepted; scan restarts at row 0.
        wait_cyc(17);
        keys[6] = 1'b1;
        exp_q.push_back(6);
        wait_cyc(250);
        chk("t1_held_pre", {31'd0, kp.key_held}, 32'd1);
        chk("t1_code_pre", {28'd0, kp.key_code}, 32'd6);
        keys = '0;
        do_reset("t1_rst");
        wait_cyc(9);
        chk("t1_row0_hold", {28'd0, kp.keypad_row}, 32'hE);
        wait_cyc(1);
        chk("t1_row1", {28'd0, kp.keypad_row}, 32'hD);
        wait_cyc(250);
        chk("t1_missing_evt", exp_q.size(), 0);

        // Bouncing key 13 then stable: one event, none during the bounce.
        exp_q.push_back(13);
        in_bounce = 1'b1;
        for (int i = 0; i < 5; i++) begin
            keys[13] = (i % 2 == 0);
            wait_cyc(20);
        end
        in_bounce = 1'b0;
        keys[13] = 1'b1;
        wait_cyc(400);
        chk("t3_bounce_quiet", bounce_hits, 0);
        chk("t3_code", {28'd0, kp.key_code}, 32'd13);
        chk("t3_missing_evt", exp_q.size(), 0);
        keys = '0;
        wait_cyc(250);
        chk("t3_released", {31'd0, kp.key_held}, 32'd0);

        // Keys 0 and 5 together: no event, never held.
        keys[0] = 1'b1;
        keys[5] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wait_cyc(50);
            chk("t4_held", {31'd0, kp.key_held}, 32'd0);
        end
        keys = '0;
        wait_cyc(250);

        // Press 3, slide to 7 without release: no event until re-press.
        keys[3] = 1'b1;
        exp_q.push_back(3);
        wait_cyc(250);
        chk("t5_code3", {28'd0, kp.key_code}, 32'd3);
        keys = '0;
        keys[7] = 1'b1;
        wait_cyc(400);
        chk("t5_code_kept", {28'd0, kp.key_code}, 32'd3);
        chk("t5_held_kept", {31'd0, kp.key_held}, 32'd1);
        keys = '0;
        wait_cyc(250);
        chk("t5_released", {31'd0, kp.key_held}, 32'd0);
        keys[7] = 1'b1;
        exp_q.push_back(7);
        wait_cyc(250);
        chk("t5_code7", {28'd0, kp.key_code}, 32'd7);
        keys = '0;
        wait_cyc(250);
        chk("t5_missing_evt", exp_q.size(), 0);

        // Key 4 held ~1 s: one event, or first event plus auto-repeats.
        keys[4] = 1'b1;
`ifdef KEYPAD_REPEAT_EN
        for (int i = 0; i < 6; i++) exp_q.push_back(4);
`else
        exp_q.push_back(4);
`endif
        wait_cyc(9800);
        keys = '0;
        wait_cyc(250);
        chk("t6_released", {31'd0, kp.key_held}, 32'd0);
        chk("t6_missing_evt", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
